// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter.
// Bundles, requester sides and the busy-bit decode helper.
package wb_arbiter_pkg;

  localparam int RegBus      = 32;
  localparam int RegAddrBus  = 5;
  localparam int RegNum      = 32;
  localparam int WbFifoDepth = 2;
  localparam int WbPtrW      = $clog2(WbFifoDepth);

  typedef logic [RegAddrBus-1:0] addr_t;
  typedef logic [RegBus-1:0]     data_t;
  typedef logic [RegNum-1:0]     busy_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wb_req_t;

  typedef enum logic {
    SideA = 1'b0,
    SideB = 1'b1
  } side_e;

  // x0 is never tracked: writes to it are discarded.
  function automatic busy_t busy_bit(input addr_t a);
    busy_t b;
    b = '0;
    if (a != '0) b[a] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester handshakes plus regfile write port and busy map.
// slave: the arbiter side; master: requesters and regfile.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic  a_valid;
  logic  a_ready;
  addr_t a_waddr;
  data_t a_wdata;

  logic  b_valid;
  logic  b_ready;
  addr_t b_waddr;
  data_t b_wdata;

  logic  we;
  addr_t waddr;
  data_t wdata;
  busy_t busy;

  modport slave (
    input  a_valid, a_waddr, a_wdata,
    input  b_valid, b_waddr, b_wdata,
    output a_ready, b_ready,
    output we, waddr, wdata, busy
  );

  modport master (
    output a_valid, a_waddr, a_wdata,
    output b_valid, b_waddr, b_wdata,
    input  a_ready, b_ready,
    input  we, waddr, wdata, busy
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Small per-requester FIFO of {addr, data} writes.
// Exposes per-slot valid/addr so the top can build busy.
module wb_arbiter_fifo
  import wb_arbiter_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  wb_req_t                        push_data_i,
  input  logic                           pop_i,
  output logic                           full_o,
  output logic                           empty_o,
  output wb_req_t                        head_o,
  output logic [WbFifoDepth-1:0]         ent_vld_o,
  output addr_t [WbFifoDepth-1:0]        ent_addr_o
);

  wb_req_t                mem_q [WbFifoDepth];
  logic [WbFifoDepth-1:0] vld_q;
  logic [WbFifoDepth-1:0] vld_d;
  logic [WbPtrW-1:0]      wptr_q;
  logic [WbPtrW-1:0]      rptr_q;
  logic                   push_acc;
  logic                   pop_acc;

  assign full_o   = &vld_q;
  assign empty_o  = ~|vld_q;
  assign head_o   = mem_q[rptr_q];
  assign push_acc = push_i && !full_o;
  assign pop_acc  = pop_i && !empty_o;
  assign ent_vld_o = vld_q;

  // Per-slot address view for the busy map.
  always_comb begin
    for (int i = 0; i < WbFifoDepth; i++) begin
      ent_addr_o[i] = mem_q[i].addr;
    end
  end

  // Slot valid flags after this cycle's pop and push.
  always_comb begin
    vld_d = vld_q;
    if (pop_acc) vld_d[rptr_q] = 1'b0;
    if (push_acc) vld_d[wptr_q] = 1'b1;
  end

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WbFifoDepth; i++) begin
        mem_q[i] <= '0;
      end
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push_acc) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_acc) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester round-robin arbiter onto the regfile write port.
// Same-register collisions drain B first to keep WAW order.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_arbiter_if.slave bus
);

  logic                   a_full, a_empty;
  logic                   b_full, b_empty;
  wb_req_t                a_push, b_push;
  wb_req_t                a_head, b_head;
  logic [WbFifoDepth-1:0] a_vld, b_vld;
  addr_t [WbFifoDepth-1:0] a_addr, b_addr;

  logic    a_hv, b_hv, same;
  logic    gnt_a, gnt_b, gnt;
  wb_req_t sel;
  side_e   ptr_q, ptr_d;
  logic    we_q;
  addr_t   waddr_q;
  data_t   wdata_q;
  busy_t   busy_c;

  assign bus.a_ready = rst && !a_full;
  assign bus.b_ready = rst && !b_full;

  assign a_push = '{addr: bus.a_waddr, data: bus.a_wdata};
  assign b_push = '{addr: bus.b_waddr, data: bus.b_wdata};

  wb_arbiter_fifo u_fifo_a (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (bus.a_valid && bus.a_ready),
    .push_data_i (a_push),
    .pop_i       (gnt_a),
    .full_o      (a_full),
    .empty_o     (a_empty),
    .head_o      (a_head),
    .ent_vld_o   (a_vld),
    .ent_addr_o  (a_addr)
  );

  wb_arbiter_fifo u_fifo_b (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (bus.b_valid && bus.b_ready),
    .push_data_i (b_push),
    .pop_i       (gnt_b),
    .full_o      (b_full),
    .empty_o     (b_empty),
    .head_o      (b_head),
    .ent_vld_o   (b_vld),
    .ent_addr_o  (b_addr)
  );

  // Grant selection; B wins same-register collisions.
  always_comb begin
    a_hv  = !a_empty;
    b_hv  = !b_empty;
    same  = a_hv && b_hv
         && (a_head.addr == b_head.addr)
         && (a_head.addr != '0);
    gnt_b = b_hv && (!a_hv || same || ptr_q == SideB);
    gnt_a = a_hv && !gnt_b;
    gnt   = gnt_a || gnt_b;
    sel   = gnt_b ? b_head : a_head;
    ptr_d = ptr_q;
    unique case (1'b1)
      gnt && !same && gnt_a: ptr_d = SideB;
      gnt && !same && gnt_b: ptr_d = SideA;
      default:               ptr_d = ptr_q;
    endcase
  end

  // Pointer and registered regfile write stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= SideA;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= gnt && (sel.addr != '0);
      if (gnt) begin
        waddr_q <= sel.addr;
        wdata_q <= sel.data;
      end
    end
  end

  // Registers with writes still queued in either FIFO.
  always_comb begin
    busy_c = '0;
    for (int i = 0; i < WbFifoDepth; i++) begin
      if (a_vld[i]) busy_c = busy_c | busy_bit(a_addr[i]);
      if (b_vld[i]) busy_c = busy_c | busy_bit(b_addr[i]);
    end
  end

  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.busy  = busy_c;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, fairness,
// WAW ordering, backpressure and x0 discard.
module tb_wb_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  wr_t  log_q[$];
  logic [31:0] rf [32];

  wb_arbiter_if bus_if ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (bus_if.we === 1'b1)
      log_q.push_back('{bus_if.waddr, bus_if.wdata, cyc});
  end

  always @(posedge clk) begin
    if (bus_if.we === 1'b1) rf[bus_if.waddr] <= bus_if.wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.a_valid = 1'b0;
    bus_if.b_valid = 1'b0;
    bus_if.a_waddr = '0;
    bus_if.b_waddr = '0;
    bus_if.a_wdata = '0;
    bus_if.b_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    log_q.delete();
  endtask

  initial begin
    logic [4:0]  fa [6];
    logic [31:0] fd [6];
    logic        brdy [40];
    wr_t         la[$];
    wr_t         lb[$];
    int ia;
    int ib;
    logic acc_a;
    logic acc_b;

    fa = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
    fd = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202};
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 40; i++) brdy[i] = 1'b0;

    // Reset state
    idle();
    #2;
    chk("rst_we", 32'(bus_if.we), 32'd0);
    chk("rst_waddr", 32'(bus_if.waddr), 32'd0);
    chk("rst_wdata", bus_if.wdata, 32'd0);
    chk("rst_busy", bus_if.busy, 32'd0);
    chk("rst_a_ready", 32'(bus_if.a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus_if.b_ready), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel_a_ready", 32'(bus_if.a_ready), 32'd1);
    chk("rel_b_ready", 32'(bus_if.b_ready), 32'd1);
    tick();

    // Reset mid-operation with queued entries
    for (int k = 0; k < 3; k++) begin
      bus_if.a_valid = 1'b1;
      bus_if.a_waddr = 5'(4 + k);
      bus_if.a_wdata = 32'h50 + 32'(k);
      bus_if.b_valid = 1'b1;
      bus_if.b_waddr = 5'(9 + k);
      bus_if.b_wdata = 32'h60 + 32'(k);
      tick();
    end
    chk("pre_busy_set", 32'(bus_if.busy != '0), 32'd1);
    rst = 1'b0;
    idle();
    #1;
    chk("mid_rst_we", 32'(bus_if.we), 32'd0);
    chk("mid_rst_busy", bus_if.busy, 32'd0);
    chk("mid_rst_a_ready", 32'(bus_if.a_ready), 32'd0);
    chk("mid_rst_b_ready", 32'(bus_if.b_ready), 32'd0);
    #1;
    log_q.delete();
    rst = 1'b1;
    tick();
    chk("post_rst_a_ready", 32'(bus_if.a_ready), 32'd1);
    chk("post_rst_b_ready", 32'(bus_if.b_ready), 32'd1);
    tick();
    tick();
    tick();
    chk("post_rst_writes", 32'(log_q.size()), 32'd0);
    chk("post_rst_busy", bus_if.busy, 32'd0);

    // Single write latency
    bus_if.a_valid = 1'b1;
    bus_if.a_waddr = 5'd5;
    bus_if.a_wdata = 32'hDEADBEEF;
    tick();
    idle();
    chk("lat_busy_n", bus_if.busy, 32'h20);
    chk("lat_we_n", 32'(bus_if.we), 32'd0);
    tick();
    chk("lat_busy_n1", bus_if.busy, 32'd0);
    chk("lat_we_n1", 32'(bus_if.we), 32'd1);
    chk("lat_waddr", 32'(bus_if.waddr), 32'd5);
    chk("lat_wdata", bus_if.wdata, 32'hDEADBEEF);
    tick();
    chk("lat_we_n2", 32'(bus_if.we), 32'd0);
    chk("lat_waddr_hold", 32'(bus_if.waddr), 32'd5);

    // Fairness
    do_reset();
    ia = 0;
    ib = 0;
    for (int k = 0; k < 30 && (ia < 3 || ib < 3); k++) begin
      bus_if.a_valid = (ia < 3);
      bus_if.a_waddr = 5'(ia + 1);
      bus_if.a_wdata = 32'h100 + 32'(ia);
      bus_if.b_valid = (ib < 3);
      bus_if.b_waddr = 5'(ib + 11);
      bus_if.b_wdata = 32'h200 + 32'(ib);
      acc_a = bus_if.a_valid && bus_if.a_ready;
      acc_b = bus_if.b_valid && bus_if.b_ready;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    idle();
    chk("fair_a_accepted", 32'(ia), 32'd3);
    chk("fair_b_accepted", 32'(ib), 32'd3);
    for (int k = 0; k < 4; k++) tick();
    chk("fair_count", 32'(log_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < log_q.size()) begin
        chk($sformatf("fair_addr%0d", k), 32'(log_q[k].addr), 32'(fa[k]));
        chk($sformatf("fair_data%0d", k), log_q[k].data, fd[k]);
        chk($sformatf("fair_cyc%0d", k),
            32'(log_q[k].cyc - log_q[0].cyc), 32'(k));
      end
    end

    // WAW on r7, then a later B entry exposes the pointer
    do_reset();
    bus_if.a_valid = 1'b1;
    bus_if.a_waddr = 5'd7;
    bus_if.a_wdata = 32'hA;
    bus_if.b_valid = 1'b1;
    bus_if.b_waddr = 5'd7;
    bus_if.b_wdata = 32'hB;
    tick();
    bus_if.a_valid = 1'b0;
    bus_if.b_waddr = 5'd9;
    bus_if.b_wdata = 32'hC;
    chk("waw_busy", bus_if.busy, 32'h80);
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    chk("waw_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("waw_first_data", log_q[0].data, 32'hB);
      chk("waw_second_data", log_q[1].data, 32'hA);
      chk("waw_second_addr", 32'(log_q[1].addr), 32'd7);
      chk("waw_third_addr", 32'(log_q[2].addr), 32'd9);
    end
    chk("waw_rf7", rf[7], 32'hA);

    // Backpressure on B while A streams
    do_reset();
    ia = 0;
    ib = 0;
    for (int k = 0; k < 40 && (ia < 6 || ib < 3); k++) begin
      bus_if.a_valid = (ia < 6);
      bus_if.a_waddr = 5'(ia + 20);
      bus_if.a_wdata = 32'h300 + 32'(ia);
      bus_if.b_valid = (ib < 3);
      bus_if.b_waddr = 5'(ib + 11);
      bus_if.b_wdata = 32'h400 + 32'(ib);
      brdy[k] = bus_if.b_ready;
      acc_a = bus_if.a_valid && bus_if.a_ready;
      acc_b = bus_if.b_valid && bus_if.b_ready;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    idle();
    chk("bp_a_accepted", 32'(ia), 32'd6);
    chk("bp_b_accepted", 32'(ib), 32'd3);
    chk("bp_b_ready_c1", 32'(brdy[1]), 32'd1);
    chk("bp_b_ready_c2", 32'(brdy[2]), 32'd0);
    chk("bp_b_ready_c3", 32'(brdy[3]), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    chk("bp_count", 32'(log_q.size()), 32'd9);
    foreach (log_q[k]) begin
      if (log_q[k].addr >= 5'd20) la.push_back(log_q[k]);
      else lb.push_back(log_q[k]);
    end
    chk("bp_b_writes", 32'(lb.size()), 32'd3);
    chk("bp_a_writes", 32'(la.size()), 32'd6);
    foreach (lb[k]) begin
      chk($sformatf("bp_b_addr%0d", k), 32'(lb[k].addr), 32'(11 + k));
      chk($sformatf("bp_b_data%0d", k), lb[k].data, 32'h400 + 32'(k));
    end
    foreach (la[k]) begin
      chk($sformatf("bp_a_data%0d", k), la[k].data, 32'h300 + 32'(k));
    end

    // x0 discard followed by a normal r3 write
    log_q.delete();
    bus_if.a_valid = 1'b1;
    bus_if.a_waddr = 5'd0;
    bus_if.a_wdata = 32'h1234;
    tick();
    bus_if.a_waddr = 5'd3;
    bus_if.a_wdata = 32'h5555;
    chk("x0_busy", bus_if.busy, 32'd0);
    chk("x0_we_n", 32'(bus_if.we), 32'd0);
    tick();
    idle();
    chk("x0_we_n1", 32'(bus_if.we), 32'd0);
    chk("x0_r3_busy", bus_if.busy, 32'h8);
    tick();
    chk("x0_r3_we", 32'(bus_if.we), 32'd1);
    chk("x0_r3_waddr", 32'(bus_if.waddr), 32'd3);
    chk("x0_r3_wdata", bus_if.wdata, 32'h5555);
    tick();
    chk("x0_log_count", 32'(log_q.size()), 32'd1);
    chk("x0_busy_end", bus_if.busy, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
